// File: rtl/cache_bus_responder_if.sv
// Cache bus request/response types and the interface bundling the cache bus
// and the request/grant/rvalid memory port seen by cache_bus_responder.
package cache_bus_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic        cached;
        logic [3:0]  burst_size;
        logic [1:0]  data_size;
        logic [31:0] addr;
        logic        data_ok;
        logic        data_last;
        logic [3:0]  data_strobe;
        logic [31:0] w_data;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;

endpackage

interface cache_bus_responder_if;
    import cache_bus_pkg::*;

    cache_bus_req_t  bus_req_i;
    cache_bus_resp_t bus_resp_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [31:0]     mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [31:0]     mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;

    // Responder side.
    modport slave (
        input  bus_req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output bus_resp_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    // Initiator plus memory side.
    modport master (
        output bus_req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  bus_resp_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/cache_bus_responder.sv
// Cache bus target endpoint: one word memory access per beat, wrapping bursts,
// read-return buffer. Define CACHE_BUS_RESP_CHECK_EN to build the sticky err_o checker.
module cache_bus_responder
    import cache_bus_pkg::*;
#(
    parameter int RBUF_DEPTH = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_bus_responder_if.slave  bus,
    output logic                  err_o
);

    localparam int PW = $clog2(RBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [3:0]      len_q, len_d;
    logic [4:0]      issued_q, issued_d;   // read grants, or accepted write beats
    logic [4:0]      ret_q, ret_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [31:0]     rbuf_q [RBUF_DEPTH];

    cache_bus_resp_t resp_c;
    logic            mem_req_c;
    logic            mem_we_c;
    logic [31:0]     mem_addr_c;
    logic [3:0]      mem_be_c;
    logic [31:0]     mem_wdata_c;

    logic            gnt_rd;
    logic            push;
    logic            pop;
    logic            rv_dec;
    logic            has_credit;
    logic            accept_c;
    logic            wr_acc_c;
    logic            wr_last_c;

    // Word bits inside the burst-aligned block advance modulo len+1; the rest stay put.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [3:0]  len,
                                              input logic [4:0]  idx);
        logic [29:0] word;
        logic [29:0] mask;
        logic [29:0] sum;
        word = base[31:2];
        mask = {26'd0, len};
        sum  = word + {25'd0, idx};
        return {(word & ~mask) | (sum & mask), 2'b00};
    endfunction

    assign has_credit = ((CW+1)'(inflight_q) + (CW+1)'(count_q)) < (CW+1)'(RBUF_DEPTH);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        ret_d       = ret_q;
        resp_c      = '0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_be_c    = '0;
        mem_wdata_c = '0;
        gnt_rd      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        rv_dec      = 1'b0;
        accept_c    = 1'b0;
        wr_acc_c    = 1'b0;
        wr_last_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.bus_req_i.valid) begin
                    accept_c     = 1'b1;
                    resp_c.ready = 1'b1;
                    base_d       = bus.bus_req_i.addr;
                    len_d        = bus.bus_req_i.burst_size;
                    ret_d        = '0;
                    if (bus.bus_req_i.write) begin
                        state_d  = S_WRITE;
                        issued_d = '0;
                    end else begin
                        // Beat 0 of a read is issued in the accept cycle to save a cycle of latency.
                        state_d    = S_READ;
                        mem_req_c  = 1'b1;
                        mem_addr_c = {bus.bus_req_i.addr[31:2], 2'b00};
                        mem_be_c   = 4'hF;
                        gnt_rd     = bus.mem_gnt_i;
                        issued_d   = {4'd0, bus.mem_gnt_i};
                    end
                end
            end

            S_READ: begin
                if (issued_q <= {1'b0, len_q} && has_credit) begin
                    mem_req_c  = 1'b1;
                    mem_addr_c = beat_addr(base_q, len_q, issued_q);
                    mem_be_c   = 4'hF;
                    gnt_rd     = bus.mem_gnt_i;
                    issued_d   = issued_q + {4'd0, bus.mem_gnt_i};
                end
                push   = bus.mem_rvalid_i && (count_q != CW'(RBUF_DEPTH));
                rv_dec = bus.mem_rvalid_i && (inflight_q != '0);
                if (count_q != '0 && bus.bus_req_i.data_ok) begin
                    pop              = 1'b1;
                    resp_c.data_ok   = 1'b1;
                    resp_c.r_data    = rbuf_q[rptr_q];
                    resp_c.data_last = (ret_q == {1'b0, len_q});
                    ret_d            = ret_q + 5'd1;
                    if (ret_q == {1'b0, len_q}) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                mem_req_c   = bus.bus_req_i.data_ok;
                mem_we_c    = 1'b1;
                mem_be_c    = bus.bus_req_i.data_strobe;
                mem_wdata_c = bus.bus_req_i.w_data;
                mem_addr_c  = beat_addr(base_q, len_q, issued_q);
                wr_last_c   = (issued_q == {1'b0, len_q});
                if (bus.bus_req_i.data_ok && bus.mem_gnt_i) begin
                    wr_acc_c         = 1'b1;
                    resp_c.data_ok   = 1'b1;
                    resp_c.data_last = wr_last_c;
                    issued_d         = issued_q + 5'd1;
                    if (wr_last_c) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        inflight_d = inflight_q + CW'(gnt_rd) - CW'(rv_dec);
        count_d    = count_q + CW'(push) - CW'(pop);
        wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
        if (state_q == S_IDLE) begin
            inflight_d = CW'(gnt_rd);
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            ret_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            ret_q      <= ret_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // NOTE: buffer storage is not reset; count and pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rbuf_q[wptr_q] <= bus.mem_rdata_i;
        end
    end

    // Outputs are forced low while reset is held, whatever the registers contain.
    assign bus.bus_resp_o  = rst_n ? resp_c      : '0;
    assign bus.mem_req_o   = rst_n & mem_req_c;
    assign bus.mem_we_o    = rst_n & mem_we_c;
    assign bus.mem_addr_o  = rst_n ? mem_addr_c  : '0;
    assign bus.mem_be_o    = rst_n ? mem_be_c    : '0;
    assign bus.mem_wdata_o = rst_n ? mem_wdata_c : '0;

`ifdef CACHE_BUS_RESP_CHECK_EN
    logic       err_q;
    logic       err_set;
    logic [4:0] beats_p1;

    always_comb begin
        beats_p1 = {1'b0, bus.bus_req_i.burst_size} + 5'd1;
        err_set  = 1'b0;
        if (wr_acc_c && (bus.bus_req_i.data_last != wr_last_c)) begin
            err_set = 1'b1;
        end
        if (accept_c && ((int'(beats_p1) > MAX_BURST) || ((beats_p1 & (beats_p1 - 5'd1)) != 5'd0))) begin
            err_set = 1'b1;
        end
        if (state_q == S_READ && bus.mem_rvalid_i && inflight_q == '0) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = rst_n & err_q;

    logic unused_fields;
    assign unused_fields = ^{bus.bus_req_i.cached, bus.bus_req_i.data_size};
`else
    assign err_o = 1'b0;

    logic unused_fields;
    assign unused_fields = ^{bus.bus_req_i.cached, bus.bus_req_i.data_size,
                             bus.bus_req_i.data_last, accept_c, wr_acc_c};
`endif

endmodule
